// File: rtl/jtag_tap.sv
// IEEE 1149.1-style TAP controller: IR, BYPASS, IDCODE and an optional user DR, all in the tck domain.
// Define JTAG_TAP_USER_DR_EN to enable the user DR and its USER instruction.
module jtag_tap #(
  parameter int unsigned IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VALUE  = 32'h000FAF01,
  parameter int unsigned USER_DR_WIDTH = 8,
  parameter logic [31:0] USER_OPCODE   = 32'h0000000A
) (
  input  logic                     tck,
  input  logic                     trst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_value,
  input  logic [USER_DR_WIDTH-1:0] user_capture_data,
  output logic [USER_DR_WIDTH-1:0] user_update_data,
  output logic                     user_update_strobe
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,  RUN_TEST_IDLE = 4'd1,  SELECT_DR = 4'd2,  SELECT_IR = 4'd3,
    CAPTURE_DR       = 4'd4,  CAPTURE_IR    = 4'd5,  SHIFT_DR  = 4'd6,  SHIFT_IR  = 4'd7,
    EXIT1_DR         = 4'd8,  EXIT1_IR      = 4'd9,  PAUSE_DR  = 4'd10, PAUSE_IR  = 4'd11,
    EXIT2_DR         = 4'd12, EXIT2_IR      = 4'd13, UPDATE_DR = 4'd14, UPDATE_IR = 4'd15
  } state_t;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IDCODE_OP  = {{(IR_WIDTH-1){1'b1}}, 1'b0};

  state_t                state;
  logic [IR_WIDTH-1:0]   ir_shift;
  logic                  bypass_reg;
  logic [31:0]           id_shift;
  logic                  sel_id;
  logic                  sel_user;
  logic                  user_lsb;

  function automatic state_t next_state(input state_t s, input logic m);
    case (s)
      TEST_LOGIC_RESET: next_state = m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    next_state = m ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        next_state = m ? SELECT_IR : CAPTURE_DR;
      SELECT_IR:        next_state = m ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR:       next_state = m ? EXIT1_DR : SHIFT_DR;
      CAPTURE_IR:       next_state = m ? EXIT1_IR : SHIFT_IR;
      SHIFT_DR:         next_state = m ? EXIT1_DR : SHIFT_DR;
      SHIFT_IR:         next_state = m ? EXIT1_IR : SHIFT_IR;
      EXIT1_DR:         next_state = m ? UPDATE_DR : PAUSE_DR;
      EXIT1_IR:         next_state = m ? UPDATE_IR : PAUSE_IR;
      PAUSE_DR:         next_state = m ? EXIT2_DR : PAUSE_DR;
      PAUSE_IR:         next_state = m ? EXIT2_IR : PAUSE_IR;
      EXIT2_DR:         next_state = m ? UPDATE_DR : SHIFT_DR;
      EXIT2_IR:         next_state = m ? UPDATE_IR : SHIFT_IR;
      UPDATE_DR:        next_state = m ? SELECT_DR : RUN_TEST_IDLE;
      UPDATE_IR:        next_state = m ? SELECT_DR : RUN_TEST_IDLE;
      default:          next_state = TEST_LOGIC_RESET;
    endcase
  endfunction

  assign sel_id = (ir_value == IDCODE_OP);

  always_ff @(posedge tck) begin
    if (trst) begin
      state      <= TEST_LOGIC_RESET;
      ir_value   <= IDCODE_OP;
      ir_shift   <= '0;
      bypass_reg <= 1'b0;
      id_shift   <= '0;
    end else begin
      state <= next_state(state, tms);
      case (state)
        CAPTURE_IR: ir_shift <= IR_CAPTURE;
        SHIFT_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
        UPDATE_IR:  ir_value <= ir_shift;
        CAPTURE_DR: begin
          bypass_reg <= 1'b0;
          if (sel_id) id_shift <= IDCODE_VALUE;
        end
        SHIFT_DR: begin
          bypass_reg <= tdi;
          if (sel_id) id_shift <= {tdi, id_shift[31:1]};
        end
        default: ;
      endcase
      // Any path into TestLogicReset restores the IDCODE instruction on arrival.
      if (next_state(state, tms) == TEST_LOGIC_RESET) ir_value <= IDCODE_OP;
    end
  end

`ifdef JTAG_TAP_USER_DR_EN
  localparam logic [IR_WIDTH-1:0] USER_OP = IR_WIDTH'(USER_OPCODE);

  logic [USER_DR_WIDTH-1:0] user_shift;
  logic [USER_DR_WIDTH:0]   user_cat;
  logic [USER_DR_WIDTH-1:0] user_data;
  logic                     user_strobe;

  // All-ones and IDCODE keep priority should USER_OPCODE collide with them.
  assign sel_user = (ir_value == USER_OP) && !sel_id && !(&ir_value);
  assign user_cat = {tdi, user_shift};
  assign user_lsb = user_shift[0];

  always_ff @(posedge tck) begin
    if (trst) begin
      user_shift  <= '0;
      user_data   <= '0;
      user_strobe <= 1'b0;
    end else begin
      user_strobe <= 1'b0;
      if (sel_user) begin
        case (state)
          CAPTURE_DR: user_shift <= user_capture_data;
          SHIFT_DR:   user_shift <= user_cat[USER_DR_WIDTH:1];
          UPDATE_DR: begin
            user_data   <= user_shift;
            user_strobe <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign user_update_data   = user_data;
  assign user_update_strobe = user_strobe;
`else
  logic unused_capture;

  assign unused_capture     = ^user_capture_data;
  assign sel_user           = 1'b0;
  assign user_lsb           = 1'b0;
  assign user_update_data   = '0;
  assign user_update_strobe = 1'b0;
`endif

  // tdo depends only on the state register and shift registers, never on tdi/tms.
  always_comb begin
    tdo = 1'b0;
    case (state)
      SHIFT_IR: tdo = ir_shift[0];
      SHIFT_DR: tdo = sel_user ? user_lsb : (sel_id ? id_shift[0] : bypass_reg);
      default:  ;
    endcase
  end

  assign tdo_en    = (state == SHIFT_DR) || (state == SHIFT_IR);
  assign tap_state = state;

endmodule

// File: tb/tb_jtag_tap.sv
// Randomised + directed bench for jtag_tap with a table-driven reference model and a queued scoreboard.
module tb_jtag_tap;
  localparam int IRW = 4;
  localparam int UW  = 8;
  localparam logic [31:0] IDV = 32'h000FAF01;
`ifdef JTAG_TAP_USER_DR_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  logic           tck = 1'b0;
  logic           trst = 1'b1;
  logic           tms = 1'b1;
  logic           tdi = 1'b0;
  logic           tdo, tdo_en;
  logic [3:0]     tap_state;
  logic [IRW-1:0] ir_value;
  logic [UW-1:0]  cap = '0;
  logic [UW-1:0]  user_update_data;
  logic           user_update_strobe;

  jtag_tap dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .tap_state(tap_state), .ir_value(ir_value), .user_capture_data(cap),
    .user_update_data(user_update_data), .user_update_strobe(user_update_strobe)
  );

  always #5 tck = ~tck;

  typedef struct {
    int st; int ir; int ud; bit tdo; bit en; bit us;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_fail = 0;

  // next state indexed by [state][tms], states numbered as in the TAP debug encoding
  int ntab[16][2] = '{'{1,0}, '{1,2}, '{4,3}, '{5,0}, '{6,8}, '{7,9}, '{6,8}, '{7,9},
                      '{10,14}, '{11,15}, '{10,12}, '{11,13}, '{6,14}, '{7,15}, '{1,2}, '{1,2}};

  int        m_st = 0, m_ir = 14, m_irsh = 0, m_ush = 0, m_ud = 0;
  bit        m_byp = 0, m_us = 0;
  bit [31:0] m_id = 0;

  // 0 = bypass, 1 = idcode, 2 = user
  function automatic int kind(input int ir);
    if (ir == 15) return 0;
    if (ir == 14) return 1;
    if (USER_EN && ir == 10) return 2;
    return 0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit m, input bit d);
    int k;
    int nst;
    exp_t e;
    if (r) begin
      m_st = 0; m_ir = 14; m_irsh = 0; m_byp = 0; m_id = 0; m_ush = 0; m_ud = 0; m_us = 0;
    end else begin
      k   = kind(m_ir);
      nst = ntab[m_st][m];
      m_us = 0;
      case (m_st)
        5:  m_irsh = 1;
        7:  m_irsh = (m_irsh >> 1) | (int'(d) << (IRW - 1));
        15: m_ir = m_irsh;
        4: begin
          if (k == 0) m_byp = 0;
          else if (k == 1) m_id = IDV;
          else m_ush = int'(cap);
        end
        6: begin
          if (k == 0) m_byp = d;
          else if (k == 1) m_id = (m_id >> 1) | (32'(d) << 31);
          else m_ush = (m_ush >> 1) | (int'(d) << (UW - 1));
        end
        14: if (k == 2) begin m_ud = m_ush; m_us = 1; end
        default: ;
      endcase
      m_st = nst;
      if (m_st == 0) m_ir = 14;
    end
    e.st = m_st; e.ir = m_ir; e.ud = m_ud; e.us = m_us;
    e.en = (m_st == 6) || (m_st == 7);
    e.tdo = 1'b0;
    if (m_st == 7) e.tdo = m_irsh[0];
    else if (m_st == 6) begin
      case (kind(m_ir))
        0: e.tdo = m_byp;
        1: e.tdo = m_id[0];
        default: e.tdo = m_ush[0];
      endcase
    end
    q.push_back(e);
  endtask

  // One tck cycle: seen is tdo during the cycle whose edge these inputs drive.
  task automatic step(input bit r, input bit m, input bit d, output bit seen);
    @(negedge tck);
    seen = tdo;
    trst = r; tms = m; tdi = d;
    model_edge(r, m, d);
  endtask

  task automatic s(input bit m);
    bit b;
    step(1'b0, m, 1'b0, b);
  endtask

  task automatic shift_bits(input int n, input logic [31:0] din, input bit ex, output logic [31:0] dout);
    bit b;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, ex && (i == n - 1), din[i], b);
      dout[i] = b;
    end
  endtask

  // From RunTestIdle: load an instruction and return to RunTestIdle.
  task automatic load_ir(input logic [IRW-1:0] v, output logic [31:0] dout);
    s(1); s(1); s(0); s(0);
    shift_bits(IRW, 32'(v), 1'b1, dout);
    s(1); s(0);
  endtask

  task automatic to_shift_dr;
    s(1); s(0); s(0);
  endtask

  // Monitor: compares every DUT cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge tck);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state",  32'(tap_state), 32'(e.st));
        check("ir",     32'(ir_value), 32'(e.ir));
        check("tdo",    32'(tdo), 32'(e.tdo));
        check("tdo_en", 32'(tdo_en), 32'(e.en));
        check("ud",     32'(user_update_data), 32'(e.ud));
        check("strobe", 32'(user_update_strobe), 32'(e.us));
      end
    end
  end

  initial begin
    logic [31:0]    dout;
    logic [IRW-1:0] v;
    bit             b;

    // reset then IDCODE readout
    step(1'b1, 1'b1, 1'b0, b);
    s(0);
    to_shift_dr();
    shift_bits(32, $urandom, 1'b1, dout);
    check("idcode_out", dout, IDV);
    check("idcode_ir", 32'(ir_value), 32'h0000000E);
    s(1); s(0);

    // IR capture pattern and BYPASS one-cycle delay
    load_ir(4'hF, dout);
    check("ir_capture", dout & 32'h3, 32'h1);
    s(0);
    check("ir_bypass", 32'(ir_value), 32'hF);
    to_shift_dr();
    shift_bits(4, 32'b1101, 1'b1, dout);
    check("bypass_out", dout, 32'b1010);
    s(1); s(0);

    // user DR capture/update (bypass when the user DR is not built)
    cap = 8'hA5;
    load_ir(4'hA, dout);
    s(0);
    to_shift_dr();
    shift_bits(8, 32'h3C, 1'b1, dout);
    check("user_out", dout, USER_EN ? 32'hA5 : 32'h78);
    s(1); s(0); s(0);
    check("user_data", 32'(user_update_data), USER_EN ? 32'h3C : 32'h0);
    check("user_strobe_hi", 32'(user_update_strobe), 32'(USER_EN));
    s(0);
    check("user_strobe_lo", 32'(user_update_strobe), 32'h0);

    // TMS reset from mid-IDCODE shift
    step(1'b1, 1'b0, 1'b0, b);
    s(0);
    to_shift_dr();
    shift_bits(10, $urandom, 1'b0, dout);
    for (int i = 0; i < 6; i++) s(1);
    check("tms_reset_state", 32'(tap_state), 32'h0);
    check("tms_reset_ir", 32'(ir_value), 32'hE);

    // trst in Exit1Dr after shifting FF into the user DR
    step(1'b1, 1'b0, 1'b0, b);
    s(0);
    load_ir(4'hA, dout);
    s(0);
    to_shift_dr();
    shift_bits(8, 32'hFF, 1'b1, dout);
    step(1'b1, 1'b1, 1'b0, b);
    s(0);
    check("trst_state", 32'(tap_state), 32'h0);
    check("trst_strobe", 32'(user_update_strobe), 32'h0);
    check("trst_data", 32'(user_update_data), 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_st == 1 && $urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: v = 4'hA;
          1: v = 4'hE;
          2: v = 4'hF;
          default: v = 4'($urandom);
        endcase
        load_ir(v, dout);
      end
      if ($urandom_range(0, 7) == 0) cap = UW'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 35, 1'($urandom), b);
    end

    repeat (3) @(posedge tck);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/jtag_tap.md
# jtag_tap

Parametrised IEEE 1149.1-style TAP controller: the next-generation replacement for the fixed 4-bit IR / IDCODE-only TAP. Adds a real IR shift/update path, a BYPASS register, an IDCODE DR that shifts continuously, and an optional user data register with parallel capture and update. Sits directly on the chip's JTAG pins and runs entirely in the `tck` domain.

## Interface
- `IR_WIDTH`, default 4: instruction register width; must be at least 2.
- `IDCODE_VALUE`, default 32'h000FAF01: 32-bit device ID; bit 0 must be 1.
- `USER_DR_WIDTH`, default 8: user data register width; must be at least 1.
- `USER_OPCODE`, default 4'b1010: opcode that selects the user DR; zero-extended or truncated to `IR_WIDTH`.
- `tck` input 1: the only clock; all state changes on its rising edge.
- `trst` input 1: synchronous, active-high reset.
- `tms` input 1: test mode select.
- `tdi` input 1: test data in.
- `tdo` output 1: test data out.
- `tdo_en` output 1: high while in ShiftDr or ShiftIr.
- `tap_state` output 4: current TAP state, for debug.
- `ir_value` output IR_WIDTH: active instruction.
- `user_capture_data` input USER_DR_WIDTH: parallel value loaded at CaptureDr.
- `user_update_data` output USER_DR_WIDTH: parallel value latched at UpdateDr.
- `user_update_strobe` output 1: one-cycle pulse on each user DR update.

## Operation
- **State encoding:** TestLogicReset=0, RunTestIdle=1, SelectDr=2, SelectIr=3, CaptureDr=4, CaptureIr=5, ShiftDr=6, ShiftIr=7, Exit1Dr=8, Exit1Ir=9, PauseDr=10, PauseIr=11, Exit2Dr=12, Exit2Ir=13, UpdateDr=14, UpdateIr=15.
- **Transitions:** standard 1149.1. From SelectIr, tms=1 goes to TestLogicReset. ShiftDr always honours tms; it never auto-exits.
- **Instructions:**
  - All-ones selects BYPASS.
  - IDCODE = {IR_WIDTH-1 ones, 0}.
  - USER_OPCODE selects the user DR.
  - Any other value decodes as BYPASS.
- **IR path:**
  - CaptureIr loads ir_shift = {zeros, 2'b01}.
  - ShiftIr shifts right: tdi enters the MSB and the LSB drives tdo.
  - UpdateIr copies ir_shift to ir_value.
  - Entering TestLogicReset sets ir_value to IDCODE.
- **DR path:** the selected DR captures in CaptureDr, shifts right in ShiftDr with tdi into the MSB, and updates in UpdateDr.
  - BYPASS: 1-bit register, captures 0.
  - IDCODE: 32-bit register, captures IDCODE_VALUE. Bits shifted in from tdi recirculate toward tdo after 32 shifts.
  - USER: captures user_capture_data. In UpdateDr it writes user_update_data and pulses user_update_strobe.
- **tdo:**
  - In ShiftIr: LSB of the IR shift register.
  - In ShiftDr: LSB of the selected DR.
  - Otherwise: 0.
  - Driven from registers only; no combinational path from tdi or tms.
- **Reset values** (trst high at a rising edge): tap_state=0, ir_value=IDCODE, all shift registers 0, tdo=0, tdo_en=0, user_update_data=0, user_update_strobe=0.
- **Reset priority:** trst overrides tms, including in the middle of a shift. No update is performed and shifted data is discarded.
- **TMS reset:** five consecutive tck edges with tms=1 reach TestLogicReset from any state.

## Timing
- Each action (capture, shift, update) happens on the rising edge at which tap_state equals the corresponding state.
- **Capture to first bit:** the first captured bit is on tdo in the first ShiftDr/ShiftIr cycle; latency 0 after entering Shift.
- **BYPASS:** tdi appears on tdo one tck later.
- **IDCODE:** the 32-bit ID appears over 32 Shift cycles.
- **user_update_strobe:** high for exactly the one cycle after the UpdateDr edge, and only when ir_value == USER_OPCODE.
- **Same-cycle IR update:** in UpdateIr, the new ir_value takes effect for the next CaptureDr. Passing through UpdateIr and then SelectDr uses the new instruction.
- **Pause:** Pause states hold all shift registers.
- **Exit2 to Shift:** resumes shifting from where it left off; no recapture.

## Configuration
- **JTAG_TAP_USER_DR_EN defined:** the user DR, the USER instruction and the user ports are active.
- **JTAG_TAP_USER_DR_EN undefined:**
  - USER_OPCODE decodes as BYPASS.
  - user_capture_data is ignored.
  - user_update_data and user_update_strobe are held at 0.
  - The port list is unchanged.

## Test plan
- **Reset then IDCODE readout:** assert trst for 1 cycle, then tms 0,1,0,0, then 32 ShiftDr cycles -> tdo LSB-first equals 32'h000FAF01; ir_value == 4'b1110.
- **IR capture and load of BYPASS:** enter ShiftIr -> first 2 tdo bits are 1 then 0. Shift in 4'b1111 and pass UpdateIr -> ir_value == 4'hF. In ShiftDr, tdi pattern 1,0,1,1 -> tdo 0,1,0,1 (one-cycle delay).
- **User DR (JTAG_TAP_USER_DR_EN):** load IR 4'b1010 and set user_capture_data=8'hA5 -> shifting out gives A5 LSB-first. Shift in 8'h3C and pass UpdateDr -> user_update_data == 8'h3C with a single-cycle strobe.
- **User DR disabled (macro undefined):** same sequence -> behaves as BYPASS; user_update_data and user_update_strobe stay 0.
- **TMS reset:** from ShiftDr mid-IDCODE, drive tms=1 for 5 cycles -> tap_state == 0, ir_value == IDCODE.
- **Reset mid-operation:** pulse trst in Exit1Dr after shifting 8'hFF into the user DR -> tap_state == 0, no strobe, user_update_data unchanged.
